// File: rtl/std_fifo_rd_stream.sv
// std_fifo_rd_stream: prefetches words from a latency-1 FIFO into a 2-entry buffer
// and presents them as a registered valid/ready stream with a wrapping beat counter.
module std_fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  o_fifo_ren,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic                  i_fifo_empty,
  output logic                  o_m_valid,
  output logic [DATA_WIDTH-1:0] o_m_data,
  input  logic                  i_m_ready,
  output logic [1:0]            o_buf_cnt,
  output logic [CNT_WIDTH-1:0]  o_beat_cnt
);
  logic [DATA_WIDTH-1:0] r_head, r_tail;
  logic [1:0]            r_cnt;
  logic                  r_pend, r_run;
  logic                  w_pop;
  logic [1:0]            w_occ;
  assign w_pop      = o_m_valid & i_m_ready;
  // occupancy after this edge, counting the word already in flight
  assign w_occ      = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  assign o_fifo_ren = r_run & ~i_fifo_empty & (w_occ <= 2'd1);
  assign o_m_valid  = r_cnt != 2'd0;
  assign o_m_data   = r_head;
  assign o_buf_cnt  = r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= 2'd0;
      r_pend     <= 1'b0;
      r_run      <= 1'b0;
      o_beat_cnt <= '0;
    end else begin
      r_run  <= 1'b1;
      r_pend <= o_fifo_ren;
      r_cnt  <= w_occ;
      if (w_pop) o_beat_cnt <= o_beat_cnt + CNT_WIDTH'(1);
      if (w_pop && r_cnt == 2'd2) r_head <= r_tail;
      if (r_pend) begin
        if (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)) r_head <= i_fifo_rdata;
        else r_tail <= i_fifo_rdata;
      end
    end
endmodule

// File: tb/tb_std_fifo_rd_stream.sv
// tb_std_fifo_rd_stream: directed checks of the FIFO read stream adapter
module tb_std_fifo_rd_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] fifo_rdata = '0;
  logic        fifo_empty;
  logic        fifo_ren, m_valid, fifo_ren4, m_valid4;
  logic [31:0] m_data, m_data4;
  logic [1:0]  buf_cnt, buf_cnt4;
  logic [15:0] beat_cnt;
  logic [3:0]  beat4;
  logic [31:0] mem [0:2047];
  int wr_cnt = 0, rd_cnt = 0;
  int n_cmp = 0, n_bad = 0;
  int exp_idx, nb, nren, nvalid, cyc_n, first_ren, first_val, last_val, nviol;
  logic pend_tb, s15, s0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt);
  always @(posedge clk)
    if (fifo_ren) begin
      fifo_rdata <= mem[rd_cnt];
      rd_cnt     <= rd_cnt + 1;
    end

  std_fifo_rd_stream #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .o_fifo_ren(fifo_ren), .i_fifo_rdata(fifo_rdata),
    .i_fifo_empty(fifo_empty), .o_m_valid(m_valid), .o_m_data(m_data),
    .i_m_ready(m_ready), .o_buf_cnt(buf_cnt), .o_beat_cnt(beat_cnt));

  std_fifo_rd_stream #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .o_fifo_ren(fifo_ren4), .i_fifo_rdata(fifo_rdata),
    .i_fifo_empty(fifo_empty), .o_m_valid(m_valid4), .o_m_data(m_data4),
    .i_m_ready(m_ready), .o_buf_cnt(buf_cnt4), .o_beat_cnt(beat4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    mem[wr_cnt] = v;
    wr_cnt++;
  endtask

  // one clock: drive ready, score the beat, then step to the next falling edge
  task automatic cyc(input logic rdy);
    logic pop;
    m_ready = rdy;
    #1;
    pop = m_valid & m_ready;
    if (pop) begin
      check("data", m_data, mem[exp_idx]);
      exp_idx++;
    end
    if (buf_cnt > 2'd2 || (buf_cnt == 2'd2 && pend_tb)) nviol++;
    if (fifo_ren) begin
      nren++;
      if (first_ren < 0) first_ren = cyc_n;
    end
    if (m_valid) begin
      nvalid++;
      if (first_val < 0) first_val = cyc_n;
      last_val = cyc_n;
    end
    pend_tb = fifo_ren;
    @(negedge clk);
    if (pop) begin
      nb++;
      check("beat", beat_cnt, nb[15:0]);
      check("beat4", beat4, nb[3:0]);
      if (beat4 == 4'd15) s15 = 1'b1;
      if (s15 && beat4 == 4'd0) s0 = 1'b1;
    end
    cyc_n++;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_ready = 1'b0;
    pend_tb = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ren", fifo_ren, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_buf", buf_cnt, 0);
    check("rst_beat", beat_cnt, 0);
    exp_idx = rd_cnt;
    nb = 0; nren = 0; nvalid = 0; cyc_n = 0; nviol = 0;
    first_ren = -1; first_val = -1; last_val = -1;
    s15 = 1'b0; s0 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    push(32'hA5A5_0001);
    do_reset();
    repeat (6) cyc(1'b1);
    check("sw_ren", nren, 1);
    check("sw_valid", nvalid, 1);
    check("sw_lat", first_val - first_ren, 2);
    check("sw_beat", beat_cnt, 1);

    for (int i = 0; i < 16; i++) push(i);
    do_reset();
    repeat (20) cyc(1'b1);
    check("bu_ren", nren, 16);
    check("bu_valid", nvalid, 16);
    check("bu_span", last_val - first_val, 15);
    check("bu_beat", beat_cnt, 16);
    check("bu_buf", buf_cnt, 0);

    for (int i = 0; i < 8; i++) push(i);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0);
      if (i >= 4) check("bp_hold", m_data, 0);
    end
    check("bp_ren", nren, 2);
    check("bp_buf", buf_cnt, 2);
    check("bp_valid", m_valid, 1);
    repeat (8) cyc(1'b1);
    check("bp_nogap", nb, 8);
    repeat (3) cyc(1'b1);
    check("bp_ren_all", nren, 8);
    check("bp_drain", buf_cnt, 0);

    for (int i = 0; i < 1000; i++) push($urandom);
    do_reset();
    for (int i = 0; i < 6000 && nb < 1000; i++) cyc(1'($urandom_range(0, 1)));
    repeat (3) cyc(1'b1);
    check("rnd_beats", nb, 1000);
    check("rnd_beat_cnt", beat_cnt, 1000);
    check("rnd_buf", buf_cnt, 0);
    check("rnd_viol", nviol, 0);

    for (int i = 0; i < 10; i++) push(200 + i);
    do_reset();
    repeat (3) cyc(1'b0);
    check("mr_buf", buf_cnt, 1);
    check("mr_pend", pend_tb, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", m_valid, 0);
    check("mr_buf0", buf_cnt, 0);
    do_reset();
    cyc(1'b1);
    check("mr_ren0", nren, 0);
    repeat (15) cyc(1'b1);
    check("mr_beats", nb, 8);
    check("mr_beat_cnt", beat_cnt, 8);
    check("mr_next", exp_idx, wr_cnt);

    for (int i = 0; i < 17; i++) push(300 + i);
    do_reset();
    repeat (25) cyc(1'b1);
    check("wr_seen15", s15, 1);
    check("wr_seen0", s0, 1);
    check("wr_end", beat4, 1);
    check("wr_beats", nb, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
